// File: rtl/guess_pkg.sv
// Shared types and constants for the number-guessing sequencer.
// The optional GUESS_DISTINCT_CHECK_EN macro is consumed by key_entry_buf.
package guess_pkg;

  localparam int NUM_DIGITS = 3;

  typedef enum logic [2:0] {
    S_SECRET = 3'd0,
    S_GUESS  = 3'd1,
    S_CHECK  = 3'd2,
    S_WIN    = 3'd3,
    S_LOSE   = 3'd4
  } state_e;

  localparam logic [3:0] KEY_CLR     = 4'hA;
  localparam logic [3:0] KEY_ENTER   = 4'hB;
  localparam logic [3:0] KEY_NEWGAME = 4'hF;

  // Index 0 is the left-most (first typed) digit.
  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  // Number of positions where the guess matches the secret exactly.
  function automatic logic [1:0] count_strikes(input digits_t guess, input digits_t secret);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (guess[i] == secret[i]) n = n + 2'd1;
    end
    return n;
  endfunction

endpackage

// File: rtl/key_entry_buf.sv
// Three-digit keypad entry buffer with CLR handling.
// Build option GUESS_DISTINCT_CHECK_EN: when defined, distinct_o reports whether
// all three buffered digits differ; otherwise distinct_o is tied high.
module key_entry_buf
  import guess_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       flush_i,
  output digits_t    buf_o,
  output logic [1:0] entry_cnt_o,
  output logic       full_o,
  output logic       distinct_o
);

  digits_t    buf_q, buf_d;
  logic [1:0] cnt_q, cnt_d;

  // Append digits while not full, clear on CLR or when the owner flushes.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      buf_d = '0;
      cnt_d = 2'd0;
    end else if (en_i && key_valid_i) begin
      if (is_digit(key_code_i)) begin
        if (cnt_q != 2'd3) begin
          buf_d[cnt_q] = key_code_i;
          cnt_d        = cnt_q + 2'd1;
        end
      end else if (key_code_i == KEY_CLR) begin
        buf_d = '0;
        cnt_d = 2'd0;
      end
    end
  end

  // Buffer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= 2'd0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

  assign buf_o       = buf_q;
  assign entry_cnt_o = cnt_q;
  assign full_o      = (cnt_q == 2'd3);

`ifdef GUESS_DISTINCT_CHECK_EN
  assign distinct_o = (buf_q[0] != buf_q[1]) && (buf_q[0] != buf_q[2]) &&
                      (buf_q[1] != buf_q[2]);
`else
  assign distinct_o = 1'b1;
`endif

endmodule

// File: rtl/guess_sequencer.sv
// Game-flow controller for the 3-digit guessing display.
// Build option GUESS_DISTINCT_CHECK_EN (see key_entry_buf) refuses entries with
// repeated digits.
//
// state    | meaning
// S_SECRET | collecting the secret number
// S_GUESS  | collecting a guess
// S_CHECK  | one cycle: score the latched guess against the secret
// S_WIN    | guess matched; win held high
// S_LOSE   | tries exhausted; lose held high
module guess_sequencer
  import guess_pkg::*;
#(
  parameter int MAX_TRIES = 10,
  parameter int TRY_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [3:0]       oNum1,
  output logic [3:0]       oNum2,
  output logic [3:0]       oNum3,
  output logic             oNumRdy,
  output logic             disp_reset,
  output logic [1:0]       entry_cnt,
  output logic [TRY_W-1:0] try_cnt,
  output logic [2:0]       game_state,
  output logic             win,
  output logic             lose,
  output logic             reject
);

  state_e           state_q, state_d;
  logic [TRY_W-1:0] try_q, try_d;
  digits_t          secret_q, secret_d;
  digits_t          num_q, num_d;
  logic             rdy_q, rdy_d;
  logic             disp_q, disp_d;
  logic             win_q, win_d;
  logic             lose_q, lose_d;
  logic             rej_q, rej_d;

  digits_t          entry_buf;
  logic             full, distinct;
  logic             newgame, in_entry, enter, submit;

  assign newgame  = key_valid && (key_code == KEY_NEWGAME);
  assign in_entry = (state_q == S_SECRET) || (state_q == S_GUESS);
  assign enter    = key_valid && (key_code == KEY_ENTER) && in_entry;
  assign submit   = enter && full && distinct && !newgame;

  key_entry_buf u_entry (
    .clk         (clk),
    .rst_n       (reset),
    .en_i        (in_entry),
    .key_valid_i (key_valid),
    .key_code_i  (key_code),
    .flush_i     (newgame || submit),
    .buf_o       (entry_buf),
    .entry_cnt_o (entry_cnt),
    .full_o      (full),
    .distinct_o  (distinct)
  );

  // Next-state and registered-output logic; NEWGAME overrides everything.
  always_comb begin
    state_d  = state_q;
    try_d    = try_q;
    secret_d = secret_q;
    num_d    = num_q;
    rdy_d    = 1'b0;
    disp_d   = 1'b0;
    rej_d    = 1'b0;
    win_d    = (state_q == S_WIN);
    lose_d   = (state_q == S_LOSE);
    if (newgame) begin
      state_d  = S_SECRET;
      try_d    = '0;
      secret_d = '0;
      num_d    = '0;
      disp_d   = 1'b1;
    end else begin
      unique case (state_q)
        S_SECRET, S_GUESS: begin
          if (submit) begin
            num_d = entry_buf;
            rdy_d = 1'b1;
            if (state_q == S_SECRET) begin
              secret_d = entry_buf;
              try_d    = '0;
              state_d  = S_GUESS;
            end else begin
              if (try_q != {TRY_W{1'b1}}) try_d = try_q + TRY_W'(1);
              state_d = S_CHECK;
            end
          end else if (enter) begin
            rej_d = 1'b1;
          end
        end
        S_CHECK: begin
          if (count_strikes(num_q, secret_q) == 2'd3) state_d = S_WIN;
          else if (try_q == TRY_W'(MAX_TRIES))        state_d = S_LOSE;
          else                                         state_d = S_GUESS;
        end
        default: ;
      endcase
    end
  end

  // State and output registers; the display clear is asserted out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_SECRET;
      try_q    <= '0;
      secret_q <= '0;
      num_q    <= '0;
      rdy_q    <= 1'b0;
      disp_q   <= 1'b1;
      win_q    <= 1'b0;
      lose_q   <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      try_q    <= try_d;
      secret_q <= secret_d;
      num_q    <= num_d;
      rdy_q    <= rdy_d;
      disp_q   <= disp_d;
      win_q    <= win_d;
      lose_q   <= lose_d;
      rej_q    <= rej_d;
    end
  end

  assign oNum1      = num_q[0];
  assign oNum2      = num_q[1];
  assign oNum3      = num_q[2];
  assign oNumRdy    = rdy_q;
  assign disp_reset = disp_q;
  assign try_cnt    = try_q;
  assign game_state = state_q;
  assign win        = win_q;
  assign lose       = lose_q;
  assign reject     = rej_q;

endmodule

// File: tb/tb_guess_sequencer.sv
// Bench for guess_sequencer: game-level model checked every cycle, plus
// literal expectations along a directed key sequence.
module tb_guess_sequencer;

  localparam int MT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] oNum1, oNum2, oNum3;
  logic       oNumRdy, disp_reset, win, lose, reject;
  logic [1:0] entry_cnt;
  logic [3:0] try_cnt;
  logic [2:0] game_state;

  int errors = 0;
  int checks = 0;

  guess_sequencer #(.MAX_TRIES(MT), .TRY_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .oNum1      (oNum1),
    .oNum2      (oNum2),
    .oNum3      (oNum3),
    .oNumRdy    (oNumRdy),
    .disp_reset (disp_reset),
    .entry_cnt  (entry_cnt),
    .try_cnt    (try_cnt),
    .game_state (game_state),
    .win        (win),
    .lose       (lose),
    .reject     (reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Game model: phase 0 secret, 1 guess, 2 scoring, 3 won, 4 lost.
  int m_phase, m_cnt, m_try, m_hits;
  int m_buf[3], m_sec[3], m_num[3];
  bit m_rdy, m_disp, m_win, m_lose, m_rej, m_ok;

  always @(posedge clk) begin
    if (!reset) begin
      m_phase = 0; m_cnt = 0; m_try = 0;
      m_buf = '{0, 0, 0}; m_sec = '{0, 0, 0}; m_num = '{0, 0, 0};
      m_rdy = 0; m_disp = 1; m_win = 0; m_lose = 0; m_rej = 0;
    end else begin
      m_win  = (m_phase == 3);
      m_lose = (m_phase == 4);
      m_rdy  = 0; m_rej = 0; m_disp = 0;
      if (key_valid && key_code == 4'hF) begin
        m_phase = 0; m_cnt = 0; m_try = 0;
        m_buf = '{0, 0, 0}; m_sec = '{0, 0, 0}; m_num = '{0, 0, 0};
        m_disp = 1;
      end else if (m_phase <= 1) begin
        if (key_valid) begin
          if (key_code <= 4'd9) begin
            if (m_cnt < 3) begin
              m_buf[m_cnt] = int'(key_code);
              m_cnt++;
            end
          end else if (key_code == 4'hA) begin
            m_cnt = 0;
          end else if (key_code == 4'hB) begin
            m_ok = (m_cnt == 3);
`ifdef GUESS_DISTINCT_CHECK_EN
            m_ok = m_ok && m_buf[0] != m_buf[1] && m_buf[0] != m_buf[2] && m_buf[1] != m_buf[2];
`endif
            if (!m_ok) m_rej = 1;
            else begin
              m_num = m_buf; m_rdy = 1; m_cnt = 0;
              if (m_phase == 0) begin
                m_sec = m_buf; m_try = 0; m_phase = 1;
              end else begin
                if (m_try < 15) m_try++;
                m_phase = 2;
              end
            end
          end
        end
      end else if (m_phase == 2) begin
        m_hits = 0;
        for (int i = 0; i < 3; i++) if (m_num[i] == m_sec[i]) m_hits++;
        if (m_hits == 3)      m_phase = 3;
        else if (m_try == MT) m_phase = 4;
        else                  m_phase = 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_onum1", oNum1, m_num[0]);
    chk("m_onum2", oNum2, m_num[1]);
    chk("m_onum3", oNum3, m_num[2]);
    chk("m_rdy", oNumRdy, m_rdy);
    chk("m_disp", disp_reset, m_disp);
    chk("m_cnt", entry_cnt, m_cnt);
    chk("m_try", try_cnt, m_try);
    chk("m_state", game_state, m_phase);
    chk("m_win", win, m_win);
    chk("m_lose", lose, m_lose);
    chk("m_rej", reject, m_rej);
  end

  task automatic key(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      key_valid = 1'b0;
      key_code  = 4'h0;
    end
  endtask

  initial begin
    reset = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_disp", disp_reset, 1);
    chk("rst_state", game_state, 0);
    chk("rst_num", {oNum1, oNum2, oNum3}, 12'h000);
    reset = 1'b1;
    @(negedge clk);
    chk("disp_drop", disp_reset, 0);

    key(1); key(2); key(3); key(4'hB); idle(1);
    chk("sec_rdy", oNumRdy, 1);
    chk("sec_num", {oNum1, oNum2, oNum3}, 12'h123);
    chk("sec_state", game_state, 1);
    chk("sec_try", try_cnt, 0);
    idle(1);
    chk("rdy_one", oNumRdy, 0);
    chk("num_hold", {oNum1, oNum2, oNum3}, 12'h123);

    key(3); key(2); key(1); key(4'hB); idle(1);
    chk("g1_rdy", oNumRdy, 1);
    chk("g1_num", {oNum1, oNum2, oNum3}, 12'h321);
    chk("g1_state", game_state, 2);
    chk("g1_try", try_cnt, 1);
    idle(1);
    chk("g1_back", game_state, 1);

    key(4); key(5); key(4'hB); idle(1);
    chk("rej_pulse", reject, 1);
    chk("rej_nordy", oNumRdy, 0);
    chk("rej_cnt", entry_cnt, 2);
    key(4'hA); key(7); key(8); key(9); key(9); idle(1);
    chk("cnt_full", entry_cnt, 3);
    chk("num_kept", {oNum1, oNum2, oNum3}, 12'h321);

    key(4'hA); key(1); key(2); key(3); key(4'hB); idle(3);
    chk("win_hi", win, 1);
    chk("win_state", game_state, 3);
    chk("win_try", try_cnt, 2);
    key(4'hB); idle(1);
    chk("win_ent_rdy", oNumRdy, 0);
    chk("win_ent_rej", reject, 0);

    key(4'hF); idle(1);
    chk("ng_disp", disp_reset, 1);
    chk("ng_state", game_state, 0);
    chk("ng_try", try_cnt, 0);
    chk("ng_num", {oNum1, oNum2, oNum3}, 12'h000);
    idle(1);
    chk("ng_disp_drop", disp_reset, 0);
    chk("ng_win_low", win, 0);

    key(1); key(2); key(3); key(4'hB);
    key(4); key(5); key(6); key(4'hB); idle(1);
    key(7); key(8); key(9); key(4'hB); idle(3);
    chk("lose_hi", lose, 1);
    chk("lose_try", try_cnt, 2);
    chk("lose_state", game_state, 4);
    key(4'hB); idle(1);
    chk("lose_ent_rdy", oNumRdy, 0);
    chk("lose_ent_rej", reject, 0);

    key(4'hF);
    key(1); key(2); key(3); key(4'hB);
    key(1); key(2); key(3); key(4'hB);
    key(4'hF); idle(1);
    chk("ngc_state", game_state, 0);
    chk("ngc_disp", disp_reset, 1);
    chk("ngc_try", try_cnt, 0);
    idle(2);
    chk("ngc_win", win, 0);
    chk("ngc_state2", game_state, 0);

    key(1); key(1); key(2); key(4'hB); idle(1);
`ifdef GUESS_DISTINCT_CHECK_EN
    chk("dup_rej", reject, 1);
    chk("dup_cnt", entry_cnt, 3);
    chk("dup_nordy", oNumRdy, 0);
`else
    chk("dup_rdy", oNumRdy, 1);
    chk("dup_num", {oNum1, oNum2, oNum3}, 12'h112);
    chk("dup_state", game_state, 1);
`endif
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/guess_sequencer.md
Name: guess_sequencer

Overview:
Game-flow controller for the 3-digit number-guessing display. It collects keypad digits into a 3-digit entry buffer and submits the secret first, then guesses, on oNum1..3 with a one-cycle oNumRdy strobe. It tracks the attempt count, detects win or lose, and issues a display-clear pulse to restart the game. It sits between the keypad decoder and the text-display controller, which latches the first ready word as the answer.

Parameters:
MAX_TRIES, 10, guesses allowed before LOSE (1..2^TRY_W-1)
TRY_W, 4, width of try_cnt

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
key_valid  in  1  one-cycle strobe, key_code valid
key_code  in  4  0-9 digit; 4'hA CLR; 4'hB ENTER; 4'hF NEWGAME; others ignored
oNum1  out  4  submitted digit, left position
oNum2  out  4  submitted digit, middle
oNum3  out  4  submitted digit, right
oNumRdy  out  1  one-cycle submit strobe
disp_reset  out  1  active-high one-cycle clear for display controller
entry_cnt  out  2  digits currently buffered (0..3)
try_cnt  out  TRY_W  guesses submitted this game
game_state  out  3  current FSM state
win  out  1  high while in S_WIN
lose  out  1  high while in S_LOSE
reject  out  1  one-cycle pulse: ENTER refused

Behaviour:
- Reset (async, reset=0):
  - state=S_SECRET.
  - buffer, entry_cnt, try_cnt, secret, oNum1..3 all =0.
  - oNumRdy=0, reject=0.
  - disp_reset=1; it drops on the first clk edge after reset release.
- States, encoding 0..4: S_SECRET, S_GUESS, S_CHECK, S_WIN, S_LOSE. All outputs registered.
- Entry buffer (S_SECRET, S_GUESS only):
  - Digit with entry_cnt<3: buf[entry_cnt] <= key_code; entry_cnt++.
  - Digit with entry_cnt==3: ignored.
  - CLR: entry_cnt<=0, buf<=0.
- ENTER with entry_cnt!=3: reject=1 next cycle; no other change.
- ENTER with entry_cnt==3:
  - Next cycle: oNum1..3 <= buf[0..2], oNumRdy=1 for exactly one cycle, entry_cnt<=0.
  - oNum1..3 hold their value until the next submit, because the display samples them continuously.
  - In S_SECRET: secret <= buf; try_cnt<=0; -> S_GUESS.
  - In S_GUESS: try_cnt <= try_cnt+1 (saturating); guess latched; -> S_CHECK.
- S_CHECK (exactly 1 cycle; all keys except NEWGAME ignored):
  - strikes = number of positions where guess digit == secret digit.
  - strikes==3 -> S_WIN.
  - else try_cnt==MAX_TRIES -> S_LOSE.
  - else -> S_GUESS.
- S_WIN / S_LOSE: digits, CLR and ENTER ignored; win or lose held high.
- NEWGAME from any state (highest priority):
  - disp_reset=1 for one cycle; buffer, entry_cnt, try_cnt, secret cleared; -> S_SECRET.
  - If oNumRdy is already high that cycle, the pulse still completes; oNum1..3 are cleared on the following cycle.
- Submission latency: ENTER strobe to oNumRdy = 1 cycle. ENTER strobe to win/lose = 3 cycles.
- Back-to-back key strobes on consecutive cycles must all be processed.

Optional Feature:
GUESS_DISTINCT_CHECK_EN:
- Defined: ENTER with entry_cnt==3 but any two buffered digits equal -> reject pulse, no submit, buffer retained. Applies to both secret and guess.
- Undefined: repeated digits accepted; reject is asserted only for incomplete entry.

Decomposition:
- Package guess_pkg holds:
  - state enum;
  - key-code constants KEY_CLR=4'hA, KEY_ENTER=4'hB, KEY_NEWGAME=4'hF;
  - NUM_DIGITS=3.
- Sub-module key_entry_buf:
  - owns the 3-digit buffer, entry_cnt, CLR/append logic and the optional distinct check;
  - exports buf and full.
- The FSM, counters and output registers stay in guess_sequencer.

Test Plan:
- Reset low 3 cycles, then release -> disp_reset=1 during reset, 0 after first edge; state=S_SECRET; all outputs 0.
- Keys 1,2,3,ENTER -> oNumRdy pulse 1 cycle with oNum=1,2,3; state S_GUESS; try_cnt=0. Then 3,2,1,ENTER -> oNumRdy; try_cnt=1; back to S_GUESS. Then 1,2,3,ENTER -> win=1; state S_WIN.
- Keys 4,5,ENTER -> reject pulse, no oNumRdy. Then CLR,7,8,9,9 -> entry_cnt=3, last 9 ignored.
- MAX_TRIES=2, secret 123, guesses 456 then 789 -> after second S_CHECK, lose=1 and try_cnt=2. Then ENTER ignored.
- NEWGAME on the same cycle S_CHECK would enter S_WIN -> state S_SECRET, disp_reset pulse, try_cnt=0, win stays 0.
- GUESS_DISTINCT_CHECK_EN defined: 1,1,2,ENTER -> reject, entry_cnt stays 3. Undefined: same input -> oNumRdy with 1,1,2.
